decoder_pipe: RTL and testbench

// Pipelined, handshaked successor to the per-warp decode stage. Accepts fetched instructions tagged with a warp id,

---
 rtl/decoder_pipe.sv | 234 +++++++++++++++++++++++
 tb/tb_decoder_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder_pipe.sv
// Shared warp decoder: decodes tagged instructions into registered bundles behind a 2-entry skid buffer.
// Optional DECODER_ILLEGAL_TRAP_EN: first illegal bundle forces finish and halts intake until reset.
package decoder_pipe_pkg;
  typedef enum logic [4:0] {
    ADD   = 5'd0,  SUB   = 5'd1,  XOR   = 5'd2,  OR    = 5'd3,  AND   = 5'd4,
    SLL   = 5'd5,  SRL   = 5'd6,  SRA   = 5'd7,  SLT   = 5'd8,  ADDI  = 5'd9,
    XORI  = 5'd10, ORI   = 5'd11, ANDI  = 5'd12, SLLI  = 5'd13, SRLI  = 5'd14,
    SRAI  = 5'd15, SLTI  = 5'd16, SLTIU = 5'd17, BEQ   = 5'd18, BNE   = 5'd19,
    BLT   = 5'd20, BGE   = 5'd21, BLTU  = 5'd22, BGEU  = 5'd23
  } alu_instruction_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FINISH = 7'b1111111;
endpackage

module decoder_pipe
  import decoder_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WARPS  = 4,
  parameter int CNT_WIDTH  = 32,
  localparam int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instruction,
  input  logic [WID_W-1:0]      in_warp_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WID_W-1:0]      out_warp_id,
  output logic                  out_reg_write_enable,
  output logic                  out_mem_write_enable,
  output logic                  out_mem_read_enable,
  output logic                  out_branch,
  output logic                  out_finish,
  output logic [1:0]            out_reg_input_mux,
  output logic [DATA_WIDTH-1:0] out_immediate,
  output logic [4:0]            out_rd_address,
  output logic [4:0]            out_rs1_address,
  output logic [4:0]            out_rs2_address,
  output alu_instruction_t      out_alu_instruction,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  decode_count
);

  typedef struct packed {
    logic [WID_W-1:0]      warp;
    logic                  rwe;
    logic                  mwe;
    logic                  mre;
    logic                  branch;
    logic                  finish;
    logic [1:0]            mux;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    alu_instruction_t      alu;
    logic                  illegal;
  } bundle_t;

  function automatic bundle_t decode(input logic [31:0] inst, input logic [WID_W-1:0] warp);
    bundle_t    b;
    logic       ill;
    logic [2:0] f3;
    logic [6:0] f7;
    f3     = inst[14:12];
    f7     = inst[31:25];
    ill    = 1'b0;
    b      = '0;
    b.warp = warp;
    b.alu  = ADDI;
    case (inst[6:0])
      OP_R: begin
        b.rwe = 1'b1; b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.rs2 = inst[24:20];
        case (f3)
          3'b000:  if (f7 == 7'b0000000) b.alu = ADD; else if (f7 == 7'b0100000) b.alu = SUB; else ill = 1'b1;
          3'b001:  b.alu = SLL;
          3'b010:  b.alu = SLT;
          3'b100:  b.alu = XOR;
          3'b101:  if (f7 == 7'b0000000) b.alu = SRL; else if (f7 == 7'b0100000) b.alu = SRA; else ill = 1'b1;
          3'b110:  b.alu = OR;
          3'b111:  b.alu = AND;
          default: ill = 1'b1;
        endcase
      end
      OP_I: begin
        b.rwe = 1'b1; b.rd = inst[11:7]; b.rs1 = inst[19:15];
        b.imm = DATA_WIDTH'($signed(inst[31:20]));
        case (f3)
          3'b000:  b.alu = ADDI;
          3'b001:  b.alu = SLLI;
          3'b010:  b.alu = SLTI;
          3'b011:  b.alu = SLTIU;
          3'b100:  b.alu = XORI;
          3'b101:  if (f7 == 7'b0000000) b.alu = SRLI; else if (f7 == 7'b0100000) b.alu = SRAI; else ill = 1'b1;
          3'b110:  b.alu = ORI;
          3'b111:  b.alu = ANDI;
          default: ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        b.rwe = 1'b1; b.mre = 1'b1; b.mux = 2'b01; b.rd = inst[11:7]; b.rs1 = inst[19:15];
        b.imm = DATA_WIDTH'($signed(inst[31:20]));
      end
      OP_S: begin
        b.mwe = 1'b1; b.rs1 = inst[19:15]; b.rs2 = inst[24:20];
        b.imm = DATA_WIDTH'($signed({inst[31:25], inst[11:7]}));
      end
      OP_B: begin
        b.branch = 1'b1; b.rs1 = inst[19:15]; b.rs2 = inst[24:20];
        b.imm = DATA_WIDTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        case (f3)
          3'b000:  b.alu = BEQ;
          3'b001:  b.alu = BNE;
          3'b100:  b.alu = BLT;
          3'b101:  b.alu = BGE;
          3'b110:  b.alu = BLTU;
          3'b111:  b.alu = BGEU;
          default: ill = 1'b1;
        endcase
      end
      OP_LUI: begin
        b.rwe = 1'b1; b.mux = 2'b10; b.rd = inst[11:7];
        b.imm = DATA_WIDTH'({inst[31:12], 12'h000});
      end
      OP_AUIPC: begin
        b.rwe = 1'b1; b.alu = ADD; b.rd = inst[11:7];
        b.imm = DATA_WIDTH'({inst[31:12], 12'h000});
      end
      OP_FINISH: b.finish = 1'b1;
      default:   ill = 1'b1;
    endcase
    if (ill) begin
      b         = '0;
      b.warp    = warp;
      b.alu     = ADDI;
      b.illegal = 1'b1;
`ifdef DECODER_ILLEGAL_TRAP_EN
      b.finish  = 1'b1;
`else
      b.finish  = 1'b0;
`endif
    end else begin
      b.illegal = 1'b0;
    end
    return b;
  endfunction

  bundle_t                head_q, head_d, skid_q, skid_d, new_s;
  logic [1:0]             count_q, count_d;
  logic                   in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic                   sticky_q, sticky_d, push_s, pop_s;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  // Buffer next-state: head is always the oldest bundle, skid only holds a second one under backpressure
  always_comb begin
    new_s   = decode(in_instruction, in_warp_id);
    push_s  = in_valid && in_ready_q;
    pop_s   = out_valid_q && out_ready;
    head_d  = head_q;
    skid_d  = skid_q;
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (count_q == 2'd0) begin head_d = new_s; count_d = 2'd1; end
        else begin skid_d = new_s; count_d = 2'd2; end
      end
      2'b01: begin
        if (count_q == 2'd2) begin head_d = skid_q; count_d = 2'd1; end
        else begin count_d = 2'd0; end
      end
      2'b11:   head_d = new_s;
      default: count_d = count_q;
    endcase
`ifdef DECODER_ILLEGAL_TRAP_EN
    sticky_d = sticky_q || (push_s && new_s.illegal);
`else
    sticky_d = 1'b0;
`endif
    in_ready_d  = (count_d != 2'd2) && !sticky_d;
    out_valid_d = (count_d != 2'd0);
    cnt_d       = cnt_q + CNT_WIDTH'(pop_s);
  end

  // State registers; reset drops both entries and presents the zero bundle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q      <= '0;
      head_q.alu  <= ADDI;
      skid_q      <= '0;
      skid_q.alu  <= ADDI;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      head_q      <= head_d;
      skid_q      <= skid_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready             = in_ready_q;
  assign out_valid            = out_valid_q;
  assign out_warp_id          = head_q.warp;
  assign out_reg_write_enable = head_q.rwe;
  assign out_mem_write_enable = head_q.mwe;
  assign out_mem_read_enable  = head_q.mre;
  assign out_branch           = head_q.branch;
  assign out_finish           = head_q.finish;
  assign out_reg_input_mux    = head_q.mux;
  assign out_immediate        = head_q.imm;
  assign out_rd_address       = head_q.rd;
  assign out_rs1_address      = head_q.rs1;
  assign out_rs2_address      = head_q.rs2;
  assign out_alu_instruction  = head_q.alu;
  assign out_illegal          = head_q.illegal;
  assign decode_count         = cnt_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Scoreboard bench for decoder_pipe: directed vectors push expected bundles, a monitor pops on each out handshake.
module tb_decoder_pipe;
  import decoder_pipe_pkg::*;

  localparam int DW = 32;
  localparam int WW = 2;
  localparam int CW = 32;
`ifdef DECODER_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instruction;
  logic [WW-1:0] in_warp_id, out_warp_id;
  logic rwe, mwe, mre, br, fin, ill;
  logic [1:0] mux;
  logic [DW-1:0] imm;
  logic [4:0] rd, rs1, rs2;
  alu_instruction_t alu;
  logic [CW-1:0] decode_count;

  typedef struct packed {
    logic [WW-1:0] warp;
    logic rwe, mwe, mre, br, fin;
    logic [1:0] mux;
    logic [DW-1:0] imm;
    logic [4:0] rd, rs1, rs2;
    alu_instruction_t alu;
    logic ill;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passed = 0;
  int sent = 0;

  decoder_pipe #(.DATA_WIDTH(DW), .NUM_WARPS(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction), .in_warp_id(in_warp_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_warp_id(out_warp_id),
    .out_reg_write_enable(rwe), .out_mem_write_enable(mwe), .out_mem_read_enable(mre),
    .out_branch(br), .out_finish(fin), .out_reg_input_mux(mux), .out_immediate(imm),
    .out_rd_address(rd), .out_rs1_address(rs1), .out_rs2_address(rs2),
    .out_alu_instruction(alu), .out_illegal(ill), .decode_count(decode_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic exp_t mk(input int w, input bit r_we, input bit m_we, input bit m_re, input bit b,
                              input bit f, input int mx, input logic [31:0] im, input int d, input int s1,
                              input int s2, input alu_instruction_t op, input bit il);
    exp_t e;
    e.warp = WW'(w); e.rwe = r_we; e.mwe = m_we; e.mre = m_re; e.br = b; e.fin = f;
    e.mux = 2'(mx); e.imm = im; e.rd = 5'(d); e.rs1 = 5'(s1); e.rs2 = 5'(s2); e.alu = op; e.ill = il;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.warp = out_warp_id; a.rwe = rwe; a.mwe = mwe; a.mre = mre; a.br = br; a.fin = fin;
    a.mux = mux; a.imm = imm; a.rd = rd; a.rs1 = rs1; a.rs2 = rs2; a.alu = alu; a.ill = ill;
    return a;
  endfunction

  // Monitor: every out handshake is compared against the oldest expectation
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_bundle", 64'd1, 64'd0);
      else check("bundle", 64'(actual()), 64'(exp_q.pop_front()));
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the posedge that accepted the instruction
  task automatic push(input logic [31:0] inst, input int w, input exp_t e);
    bit ok = 1'b0;
    in_valid = 1'b1; in_instruction = inst; in_warp_id = WW'(w);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin exp_q.push_back(e); sent++; ok = 1'b1; end
    end
    if (!ok) check("push_timeout", 64'd0, 64'd1);
    sync();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    sync();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    time t0;
    in_valid = 1'b0; in_instruction = 32'h0; in_warp_id = '0; out_ready = 1'b0; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_count", 64'(decode_count), 64'd0);
    check("rst_bundle", 64'(actual()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, ADDI, 0)));
    reset_n = 1'b1;
    #1 check("ready_before_first_clk", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("ready_after_release", 64'(in_ready), 64'd1);
    sync();

    out_ready = 1'b1;
    push(32'hFFD08293, 1, mk(1, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFD, 5, 1, 0, ADDI, 0));
    @(negedge clk);
    check("addi_latency", 64'(out_valid), 64'd1);
    sync();
    push(32'hFE208CE3, 2, mk(2, 0, 0, 0, 1, 0, 0, 32'hFFFFFFF8, 0, 1, 2, BEQ, 0));
    push(32'h123451B7, 3, mk(3, 1, 0, 0, 0, 0, 2, 32'h12345000, 3, 0, 0, ADDI, 0));
    push(32'hABCDE217, 0, mk(0, 1, 0, 0, 0, 0, 0, 32'hABCDE000, 4, 0, 0, ADD, 0));
    push(32'h00812303, 1, mk(1, 1, 0, 1, 0, 0, 1, 32'h00000008, 6, 2, 0, ADDI, 0));
    push(32'hFE742E23, 2, mk(2, 0, 1, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 8, 7, ADDI, 0));
    push(32'h40B504B3, 3, mk(3, 1, 0, 0, 0, 0, 0, 32'h0, 9, 10, 11, SUB, 0));
    push(32'h4056D613, 0, mk(0, 1, 0, 0, 0, 0, 0, 32'h00000405, 12, 13, 0, SRAI, 0));
    push(32'h0000007F, 1, mk(1, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0, 0, ADDI, 0));
    drain();

    // Backpressure: two entries fill the buffer, the third must wait
    out_ready = 1'b0;
    push(32'h00100093, 0, mk(0, 1, 0, 0, 0, 0, 0, 32'h1, 1, 0, 0, ADDI, 0));
    push(32'h00200113, 1, mk(1, 1, 0, 0, 0, 0, 0, 32'h2, 2, 0, 0, ADDI, 0));
    in_valid = 1'b1; in_instruction = 32'h00300193; in_warp_id = 2'd2;
    @(negedge clk);
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    check("bp_head_held", 64'(actual()), 64'(exp_q[0]));
    @(negedge clk);
    check("bp_head_stable", 64'(actual()), 64'(exp_q[0]));
    sync();
    out_ready = 1'b1;
    push(32'h00300193, 2, mk(2, 1, 0, 0, 0, 0, 0, 32'h3, 3, 0, 0, ADDI, 0));
    drain();

    // Streaming: one instruction per cycle with rotating warp tags
    t0 = $time;
    for (int i = 0; i < 100; i++)
      push((32'(i) << 20) | (32'(i % 32) << 7) | 32'h13, i % 4,
           mk(i % 4, 1, 0, 0, 0, 0, 0, 32'(i), i % 32, 0, 0, ADDI, 0));
    check("stream_cycles", 64'(($time - t0) / 10), 64'd100);
    drain();
    check("stream_decode_count", 64'(decode_count), 64'(sent));

    push(32'h023100B3, 0, mk(0, 0, 0, 0, 0, TRAP, 0, 32'h0, 0, 0, 0, ADDI, 1));
`ifdef DECODER_ILLEGAL_TRAP_EN
    drain();
    repeat (5) @(negedge clk);
    check("trap_halts_intake", 64'(in_ready), 64'd0);
    check("trap_decode_count", 64'(decode_count), 64'(sent));
    sync();
`else
    push(32'h0020B033, 1, mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, ADDI, 1));
    push(32'h00102063, 2, mk(2, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, ADDI, 1));
    push(32'h00000073, 3, mk(3, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, ADDI, 1));
    push(32'h0200D093, 0, mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, ADDI, 1));
    push(32'h0000000B, 1, mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, ADDI, 1));
    push(32'h00100093, 2, mk(2, 1, 0, 0, 0, 0, 0, 32'h1, 1, 0, 0, ADDI, 0));
    drain();
    check("illegal_no_stall", 64'(in_ready), 64'd1);
    check("illegal_decode_count", 64'(decode_count), 64'(sent));
`endif

    // Reset with both entries occupied
    reset_n = 1'b0;
    sync();
    reset_n = 1'b1;
    sync();
    sync();
    out_ready = 1'b0;
    sent = 0;
    push(32'h00100093, 0, mk(0, 1, 0, 0, 0, 0, 0, 32'h1, 1, 0, 0, ADDI, 0));
    push(32'h00200113, 1, mk(1, 1, 0, 0, 0, 0, 0, 32'h2, 2, 0, 0, ADDI, 0));
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    check("pre_reset_full", 64'(in_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(out_valid), 64'd0);
    check("async_reset_count", 64'(decode_count), 64'd0);
    exp_q.delete();
    sent = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_valid", 64'(out_valid), 64'd0);
    check("post_reset_ready", 64'(in_ready), 64'd1);
    check("post_reset_count", 64'(decode_count), 64'd0);
    sync();
    push(32'hFFD08293, 3, mk(3, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFD, 5, 1, 0, ADDI, 0));
    drain();
    check("final_decode_count", 64'(decode_count), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
